usb_bulk_in_fifo: RTL and testbench
===================================

USB_BULK_IN_FIFO -- requirements
Module: usb_bulk_in_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11; byte-RAM depth is 2^ADDR_WIDTH.
REQ-002 SHALL have parameter MAX_PACKET, default 512; maximum bulk-IN packet length in bytes (64 when HIGH_SPEED=0).
REQ-003 SHALL have parameter PKT_CNT_WIDTH, default 4; width of the committed-packet counter.
REQ-004 Port clk, input, 1: single clock (usb_clk domain); all logic rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port abort_i, input, 1: discard the uncommitted partial packet.
REQ-007 Ports s_tvalid_i / s_tready_o / s_tlast_i, 1 each, in/out/in: application write stream.
REQ-008 Port s_tdata_i, input, 8: write data.
REQ-009 Port bid_has_data_o, output, 1: at least one complete packet is stored.
REQ-010 Ports bid_tvalid_o / bid_tready_i / bid_tlast_o, 1 each, out/in/out: read stream toward the bulk-IN endpoint.
REQ-011 Port bid_tdata_o, output, 8: read data.
REQ-012 Port level_o, output, ADDR_WIDTH+1: bytes stored, committed plus uncommitted.

Function
REQ-013 Storage SHALL be a 9-bit RAM holding {tlast, data}, with (ADDR_WIDTH+1)-bit write, commit and read pointers that wrap modulo 2^(ADDR_WIDTH+1).
REQ-014 A write beat SHALL be accepted when s_tvalid_i && s_tready_o; s_tready_o = (level_o < 2^ADDR_WIDTH) && (packet counter not at maximum).
REQ-015 A write-side byte counter SHALL count beats of the current packet; a beat SHALL be stored with tlast=1 when s_tlast_i=1 or the counter equals MAX_PACKET-1.
REQ-016 A beat stored with tlast=1 SHALL commit the packet: commit pointer <= write pointer + 1, packet counter increments, byte counter clears. An input packet longer than MAX_PACKET is therefore split into MAX_PACKET-byte packets.
REQ-017 abort_i=1 SHALL set the write pointer to the commit pointer and clear the byte counter in the same cycle; any write beat in that cycle is dropped and s_tready_o is 0. Committed packets are unaffected.
REQ-018 bid_has_data_o SHALL equal (packet counter != 0), registered: high one cycle after the committing write edge.
REQ-019 Read data SHALL be presented only from committed bytes (read pointer != commit pointer), through a one-entry output register fed by a one-cycle-latency RAM read. A packet committed at edge N with the read side idle SHALL give bid_tvalid_o=1 after edge N+2.
REQ-020 The output register SHALL hold bid_tdata_o/bid_tlast_o stable while bid_tvalid_o && !bid_tready_i. Under continuous bid_tready_i=1, one byte per cycle with no bubbles inside a packet or between back-to-back committed packets.
REQ-021 A read handshake with bid_tlast_o=1 SHALL decrement the packet counter.
REQ-022 A simultaneous commit and tlast-read SHALL leave the packet counter unchanged; a simultaneous write and read SHALL leave level_o unchanged.
REQ-023 level_o SHALL equal write pointer minus read pointer, modulo 2^(ADDR_WIDTH+1).
REQ-024 Zero-length packets are not supported: s_tlast_i is always qualified by a data beat.

Reset
REQ-025 While rst_n=0, all pointers, the byte counter, the packet counter and the output register SHALL clear asynchronously: bid_tvalid_o=0, bid_tlast_o=0, bid_tdata_o=0, bid_has_data_o=0, level_o=0, s_tready_o=0.
REQ-026 s_tready_o SHALL rise on the first clk edge after rst_n deasserts. Reset mid-packet SHALL discard all stored data; RAM contents need not clear.

Verification
REQ-027 Write 10 bytes 0x00..0x09 with tlast on the last -> bid_has_data_o=1 one cycle later; read returns 0x00..0x09, bid_tlast_o on 0x09; bid_has_data_o=0 after that read.
REQ-028 Write a 1200-byte packet (MAX_PACKET=512) -> three packets of 512, 512 and 176 bytes, each ending in tlast; counter peaks at 3.
REQ-029 Write 5 bytes, pulse abort_i, then write 3 bytes with tlast -> read side sees exactly the 3-byte packet; level_o=3 before the read.
REQ-030 Fill to 2048 bytes with reader stalled -> s_tready_o=0 with level_o=2048; one read re-enables s_tready_o the next cycle; data order is preserved across pointer wrap.
REQ-031 Stream 4-byte packets while bid_tready_i toggles randomly -> no byte lost or duplicated, bid_tdata_o stable during stalls; the counter holds its value on simultaneous commit and tlast-read.
REQ-032 Assert rst_n=0 mid-read of a committed packet -> all outputs are 0 immediately; after release, bid_has_data_o=0 and level_o=0.

Source files
------------

// File: rtl/usb_bulk_in_fifo_if.sv
// Stream bundle for the bulk-IN packet FIFO: application write side, endpoint read side,
// packet/level status and abort.
interface usb_bulk_in_fifo_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  abort_i;
  logic                  s_tvalid_i;
  logic                  s_tready_o;
  logic                  s_tlast_i;
  logic [7:0]            s_tdata_i;
  logic                  bid_has_data_o;
  logic                  bid_tvalid_o;
  logic                  bid_tready_i;
  logic                  bid_tlast_o;
  logic [7:0]            bid_tdata_o;
  logic [ADDR_WIDTH:0]   level_o;

  modport slave (
    input  abort_i, s_tvalid_i, s_tlast_i, s_tdata_i, bid_tready_i,
    output s_tready_o, bid_has_data_o, bid_tvalid_o, bid_tlast_o, bid_tdata_o, level_o
  );

  modport master (
    output abort_i, s_tvalid_i, s_tlast_i, s_tdata_i, bid_tready_i,
    input  s_tready_o, bid_has_data_o, bid_tvalid_o, bid_tlast_o, bid_tdata_o, level_o
  );
endinterface

// File: rtl/usb_bulk_in_fifo.sv
// Packet-mode byte FIFO feeding a USB bulk-IN endpoint: bytes become visible to the reader
// only once their packet is committed; long packets are split at MAX_PACKET bytes.
module usb_bulk_in_fifo #(
  parameter int ADDR_WIDTH    = 11,
  parameter int MAX_PACKET    = 512,
  parameter int PKT_CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  usb_bulk_in_fifo_if.slave  bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BW    = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;

  logic [8:0]               mem [DEPTH];
  logic [PW-1:0]            wr_ptr, cm_ptr, rd_ptr, level;
  logic [BW-1:0]            byte_cnt;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt;
  logic                     run, has_data;
  logic [8:0]               ram_q;
  logic                     ram_vld;
  logic [7:0]               out_data;
  logic                     out_last, out_vld;
  logic                     ready, wr_en, wr_last, commit, issue, out_load, rd_done;

  assign level    = wr_ptr - rd_ptr;
  assign ready    = run && !bus.abort_i && (level < PW'(DEPTH)) && (pkt_cnt != '1);
  assign wr_en    = bus.s_tvalid_i && ready;
  assign wr_last  = bus.s_tlast_i || (byte_cnt == BW'(MAX_PACKET - 1));
  assign commit   = wr_en && wr_last;
  // RAM-read stage refills whenever it is empty or draining into the output register
  assign out_load = ram_vld && (!out_vld || bus.bid_tready_i);
  assign issue    = (rd_ptr != cm_ptr) && (!ram_vld || out_load);
  assign rd_done  = out_vld && bus.bid_tready_i && out_last;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_last, bus.s_tdata_i};
    if (issue) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      byte_cnt <= '0;
      pkt_cnt  <= '0;
      has_data <= 1'b0;
    end else begin
      run      <= 1'b1;
      has_data <= (pkt_cnt != '0);
      if (bus.abort_i) begin
        wr_ptr   <= cm_ptr;
        byte_cnt <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (wr_last) begin
          cm_ptr   <= wr_ptr + PW'(1);
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
      end
      case ({commit, rd_done})
        2'b10:   pkt_cnt <= pkt_cnt + PKT_CNT_WIDTH'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PKT_CNT_WIDTH'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      ram_vld  <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr  <= rd_ptr + PW'(1);
        ram_vld <= 1'b1;
      end else if (out_load) begin
        ram_vld <= 1'b0;
      end
      if (out_load) begin
        out_vld  <= 1'b1;
        out_data <= ram_q[7:0];
        out_last <= ram_q[8];
      end else if (out_vld && bus.bid_tready_i) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.s_tready_o     = ready;
  assign bus.bid_has_data_o = has_data;
  assign bus.bid_tvalid_o   = out_vld;
  assign bus.bid_tdata_o    = out_data;
  assign bus.bid_tlast_o    = out_last;
  assign bus.level_o        = level;
endmodule

// File: tb/tb_usb_bulk_in_fifo.sv
// Scoreboard bench for usb_bulk_in_fifo: writers push expected {tlast,data} on acceptance,
// a negedge monitor pops and compares every read handshake and checks stall stability.
module tb_usb_bulk_in_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] exp_q[$];
  logic rand_rd = 1'b0;
  logic stalled = 1'b0;
  logic [8:0] held;
  logic [8:0] exp_item;

  always #5 clk = ~clk;

  usb_bulk_in_fifo_if #(.ADDR_WIDTH(11)) bus ();

  usb_bulk_in_fifo #(.ADDR_WIDTH(11), .MAX_PACKET(512), .PKT_CNT_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One write beat; pushes the expected read item when keep is set.
  task automatic wr_beat(input logic [7:0] d, input logic l, input bit keep, input logic exp_last);
    int n;
    n = 0;
    bus.s_tvalid_i = 1'b1;
    bus.s_tdata_i  = d;
    bus.s_tlast_i  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_tready_o && n < 5000);
    if (!bus.s_tready_o) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: got s_tready_o=0 expected 1 within 5000 cycles");
    end
    step(1);
    if (keep) exp_q.push_back({exp_last, d});
  endtask

  task automatic wr_pkt(input int n, input logic [7:0] base, input bit keep, input bit last_on_end);
    logic l;
    for (int i = 0; i < n; i++) begin
      l = last_on_end && (i == n - 1);
      wr_beat(base + 8'(i), l, keep, l || ((i % 512) == 511));
    end
    bus.s_tvalid_i = 1'b0;
    bus.s_tlast_i  = 1'b0;
  endtask

  // Writes until s_tready_o stays low; every accepted beat is kept.
  task automatic fill(input bit one_byte_pkts, output int n);
    int idle;
    logic [7:0] d;
    n = 0;
    idle = 0;
    bus.s_tvalid_i = 1'b1;
    while (idle < 8 && n < 3000) begin
      d = one_byte_pkts ? 8'(n + 16) : 8'(n ^ (n >> 8));
      bus.s_tdata_i = d;
      bus.s_tlast_i = one_byte_pkts;
      @(negedge clk);
      if (bus.s_tready_o) begin
        step(1);
        exp_q.push_back({one_byte_pkts || ((n % 512) == 511), d});
        n++;
        idle = 0;
      end else begin
        step(1);
        idle++;
      end
    end
    bus.s_tvalid_i = 1'b0;
    bus.s_tlast_i  = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      step(1);
      cyc++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #3;
    if (rand_rd) bus.bid_tready_i = 1'($urandom_range(0, 1));
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (!bus.bid_tvalid_o || {bus.bid_tlast_o, bus.bid_tdata_o} !== held) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b item=%0h expected valid=1 item=%0h",
                     bus.bid_tvalid_o, {bus.bid_tlast_o, bus.bid_tdata_o}, held);
          end
        end
        if (bus.bid_tvalid_o && bus.bid_tready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected: got item=%0h expected no output",
                     {bus.bid_tlast_o, bus.bid_tdata_o});
          end else begin
            exp_item = exp_q.pop_front();
            if ({bus.bid_tlast_o, bus.bid_tdata_o} !== exp_item) begin
              errors++;
              $display("FAIL read_item: got {last,data}=%0h expected %0h",
                       {bus.bid_tlast_o, bus.bid_tdata_o}, exp_item);
            end
          end
        end
        stalled = bus.bid_tvalid_o && !bus.bid_tready_i;
        held    = {bus.bid_tlast_o, bus.bid_tdata_o};
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got no finish expected finish before 3ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    int n;
    bus.abort_i      = 1'b0;
    bus.s_tvalid_i   = 1'b0;
    bus.s_tlast_i    = 1'b0;
    bus.s_tdata_i    = '0;
    bus.bid_tready_i = 1'b0;

    // Reset state and ready release
    step(2);
    chk("rst_tready", bus.s_tready_o, 0);
    chk("rst_tvalid", bus.bid_tvalid_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_has_data", bus.bid_has_data_o, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_tready_before_edge", bus.s_tready_o, 0);
    step(1);
    chk("rel_tready_after_edge", bus.s_tready_o, 1);

    // 10-byte packet: commit/has_data/valid latency then readback
    wr_pkt(10, 8'h00, 1, 1);
    chk("p10_level", bus.level_o, 10);
    chk("p10_has_data_n", bus.bid_has_data_o, 0);
    chk("p10_tvalid_n", bus.bid_tvalid_o, 0);
    step(1);
    chk("p10_has_data_n1", bus.bid_has_data_o, 1);
    chk("p10_tvalid_n1", bus.bid_tvalid_o, 0);
    step(1);
    chk("p10_tvalid_n2", bus.bid_tvalid_o, 1);
    chk("p10_first_data", bus.bid_tdata_o, 8'h00);
    bus.bid_tready_i = 1'b1;
    drain("p10_drain", 100, cyc);
    step(3);
    chk("p10_has_data_end", bus.bid_has_data_o, 0);
    chk("p10_level_end", bus.level_o, 0);

    // Abort discards the partial packet and a concurrent beat
    bus.bid_tready_i = 1'b0;
    wr_pkt(5, 8'hA0, 0, 0);
    chk("abort_level_pre", bus.level_o, 5);
    bus.abort_i    = 1'b1;
    bus.s_tvalid_i = 1'b1;
    bus.s_tdata_i  = 8'hEE;
    #1;
    chk("abort_tready", bus.s_tready_o, 0);
    step(1);
    bus.abort_i    = 1'b0;
    bus.s_tvalid_i = 1'b0;
    chk("abort_level_post", bus.level_o, 0);
    wr_pkt(3, 8'hB0, 1, 1);
    chk("abort_level_3", bus.level_o, 3);
    bus.bid_tready_i = 1'b1;
    drain("abort_drain", 100, cyc);
    step(3);
    chk("abort_has_data_end", bus.bid_has_data_o, 0);

    // 1200-byte packet splits into 512/512/176; drained without bubbles
    bus.bid_tready_i = 1'b0;
    wr_pkt(1200, 8'h00, 1, 1);
    step(3);
    chk("split_has_data", bus.bid_has_data_o, 1);
    bus.bid_tready_i = 1'b1;
    drain("split_drain", 1300, cyc);
    chk("split_cycles", cyc, 1200);
    step(3);
    chk("split_has_data_end", bus.bid_has_data_o, 0);

    // Packet counter saturation: 15 one-byte packets then ready drops
    bus.bid_tready_i = 1'b0;
    fill(1, n);
    chk("pktmax_count", n, 15);
    chk("pktmax_tready", bus.s_tready_o, 0);
    bus.bid_tready_i = 1'b1;
    drain("pktmax_drain", 100, cyc);
    step(3);
    chk("pktmax_has_data_end", bus.bid_has_data_o, 0);

    // Full FIFO with stalled reader, single read reopens, pointers wrap
    bus.bid_tready_i = 1'b0;
    fill(0, n);
    chk("full_level", bus.level_o, 2048);
    chk("full_tready", bus.s_tready_o, 0);
    bus.bid_tready_i = 1'b1;
    step(1);
    bus.bid_tready_i = 1'b0;
    chk("full_level_after_read", bus.level_o, 2047);
    chk("full_tready_after_read", bus.s_tready_o, 1);
    wr_pkt(1, 8'h5A, 1, 1);
    bus.bid_tready_i = 1'b1;
    drain("full_drain", 2200, cyc);
    step(3);
    chk("full_level_end", bus.level_o, 0);
    chk("full_has_data_end", bus.bid_has_data_o, 0);

    // 4-byte packets against a randomly stalling reader
    rand_rd = 1'b1;
    for (int p = 0; p < 20; p++) wr_pkt(4, 8'(8'h40 + p * 4), 1, 1);
    drain("rand_drain", 2000, cyc);
    rand_rd = 1'b0;
    step(1);
    bus.bid_tready_i = 1'b1;
    step(3);
    chk("rand_has_data_end", bus.bid_has_data_o, 0);
    chk("rand_level_end", bus.level_o, 0);

    // Reset in the middle of reading a committed packet
    bus.bid_tready_i = 1'b0;
    wr_pkt(6, 8'hC0, 1, 1);
    step(3);
    bus.bid_tready_i = 1'b1;
    step(2);
    rst_n = 1'b0;
    exp_q.delete();
    bus.bid_tready_i = 1'b0;
    #1;
    chk("mid_rst_tvalid", bus.bid_tvalid_o, 0);
    chk("mid_rst_tlast", bus.bid_tlast_o, 0);
    chk("mid_rst_tdata", bus.bid_tdata_o, 0);
    chk("mid_rst_has_data", bus.bid_has_data_o, 0);
    chk("mid_rst_level", bus.level_o, 0);
    chk("mid_rst_tready", bus.s_tready_o, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_tready", bus.s_tready_o, 1);
    step(3);
    chk("post_rst_has_data", bus.bid_has_data_o, 0);
    chk("post_rst_level", bus.level_o, 0);
    chk("post_rst_tvalid", bus.bid_tvalid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
